divider: RTL and testbench
==========================

DIVIDER -- requirements
Module: divider

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; single clock domain.
REQ-002 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: input_a  in  16  dividend, bfloat16 (float32 bits [31:16]).
REQ-004 SHALL have ports: input_b  in  16  divisor, bfloat16.
REQ-005 SHALL have ports: div_input_STB  in  1  input valid.
REQ-006 SHALL have ports: div_BUSY  out  1  operands held and operation in progress; not ready for input.
REQ-007 SHALL have ports: output_div  out  16  quotient, bfloat16.
REQ-008 SHALL have ports: div_output_STB  out  1  output valid.
REQ-009 SHALL have ports: output_module_BUSY  in  1  downstream not ready.
REQ-010 SHALL have parameter: none; widths are fixed.

Function
REQ-011 SHALL accept operands in state get_a_and_b when div_BUSY=0 and div_input_STB=1, latching a={input_a,16'b0} and b={input_b,16'b0}, and SHALL set div_BUSY=1 on the same edge.
REQ-012 SHALL compute the quotient in the float32 domain with round-to-nearest-even, and SHALL output the upper 16 bits of the result with no further rounding.
REQ-013 SHALL use states get_a_and_b, unpack, special_cases, normalise_a, normalise_b, divide_0, divide_1, divide_2, normalise_1, normalise_2, round, pack, put_z, in that order; special cases SHALL jump from special_cases directly to put_z.
REQ-014 unpack SHALL perform: mantissa = bits[22:0]; exponent = bits[30:23]-127 (10-bit signed); sign = bit 31.
REQ-015 special_cases SHALL apply these rules, first match wins:
- either operand NaN -> 0xFFC00000
- a inf and b inf -> NaN
- a inf -> inf with sign a_s^b_s
- b inf -> signed zero
- b zero and a zero -> NaN
- b zero -> signed inf
- a zero -> signed zero
- otherwise: a denormal sets exponent -126, else sets implicit bit 23; same for b.
REQ-016 normalise_a and normalise_b SHALL each shift the mantissa left and decrement the exponent, one bit per cycle, until bit 23 is set.
REQ-017 divide_0 SHALL set z_s=a_s^b_s, set z_e=a_e-b_e, load dividend=a_m<<26 (50 bits), divisor=b_m, quotient=0, remainder=0, count=0.
REQ-018 divide_1 SHALL perform one restoring shift-subtract step per cycle for exactly 27 cycles, producing the 27-bit quotient Q = floor(a_m*2^26/b_m) and remainder R.
REQ-019 divide_2 SHALL set z_m=Q[26:3], guard=Q[2], round_bit=Q[1], sticky=Q[0]|(R!=0).
REQ-020 normalise_1 SHALL, while z_m[23]=0, shift z_m left with guard entering bit 0, set guard=round_bit and round_bit=0, and decrement z_e.
REQ-021 normalise_2 SHALL, while z_e<-126, shift z_m right, increment z_e, and fold shifted-out bits into guard, round_bit and sticky.
REQ-022 round SHALL increment z_m when guard&(round_bit|sticky|z_m[0]); on carry-out (z_m==24'hFFFFFF) it SHALL also increment z_e.
REQ-023 pack SHALL set exponent field = z_e+127, or 0 if z_e=-126 and z_m[23]=0; if z_e>127 it SHALL output signed inf.
REQ-024 put_z SHALL set div_output_STB=1 and output_div=z[31:16]; when div_output_STB=1 and output_module_BUSY=0 it SHALL clear div_output_STB and return to get_a_and_b.
REQ-025 output_div SHALL be held stable while div_output_STB=1, for any duration of output_module_BUSY=1.
REQ-026 div_BUSY SHALL remain 1 from accept until the cycle after return to get_a_and_b; input changes while div_BUSY=1 SHALL be ignored.
REQ-027 latency from the accept edge to div_output_STB=1 SHALL be 38 cycles for normal operands with a_m>=b_m, 39 cycles for a_m<b_m, plus 1 cycle per denormal normalisation shift.
REQ-028 latency for special cases SHALL be 3 cycles.

Reset
REQ-029 rst=1 on a clock edge SHALL force state=get_a_and_b, div_BUSY=0, div_output_STB=0, overriding any state transition on that edge, including mid-division and during put_z.
REQ-030 output_div and datapath registers SHALL be don't-care after reset; no valid output is claimed.
REQ-031 the first accept after rst deasserts SHALL be possible on the first clock edge with rst=0.

Structure
REQ-032 a shared package fp_pkg SHALL hold the state encodings (4-bit), the bias (127), the NaN constant (0xFFC00000), the inf exponent (255) and the minimum normal exponent (-126).
REQ-033 the divider SHALL be a single module; the restoring step SHALL be inline in divide_1, with no sub-module.
REQ-034 the module SHALL include a simulation-only ASCII state-name register for waveform debugging.

Verification
REQ-035 input_a=0x40C0 (6.0), input_b=0x4000 (2.0) -> output_div=0x4040 with div_output_STB high 38 cycles after accept.
REQ-036 input_a=0x3F80, input_b=0x4040 (1/3) -> output_div=0x3EAA, 39-cycle latency.
REQ-037 special cases:
- 0x3F80/0x0000 -> 0x7F80
- 0x0000/0x0000 -> 0xFFC0
- 0xBF80/0x7F80 -> 0x8000
- each with 3-cycle latency.
REQ-038 output_module_BUSY=1 for 10 cycles during put_z -> div_output_STB and output_div stable and div_BUSY=1 throughout; after release, STB drops one cycle later and div_BUSY drops one cycle after that.
REQ-039 rst=1 pulsed during divide_1 -> div_BUSY=0 and STB=0 next cycle; a new operation 0x4000/0x3F80 then returns 0x4000.
REQ-040 input held valid with new operands while div_BUSY=1 -> ignored; the first result is unchanged and the second operation is accepted only from get_a_and_b.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared encodings and float32 constants for the bfloat16 divider.
// Exponents are held unbiased as 10-bit signed values throughout the datapath.
package fp_pkg;

   typedef enum logic [3:0] {
      get_a_and_b   = 4'd0,
      unpack        = 4'd1,
      special_cases = 4'd2,
      normalise_a   = 4'd3,
      normalise_b   = 4'd4,
      divide_0      = 4'd5,
      divide_1      = 4'd6,
      divide_2      = 4'd7,
      normalise_1   = 4'd8,
      normalise_2   = 4'd9,
      round         = 4'd10,
      pack          = 4'd11,
      put_z         = 4'd12
   } state_t;

   localparam logic signed [9:0] BIAS           = 10'sd127;
   localparam logic [31:0]       NAN_BITS       = 32'hFFC0_0000;
   localparam logic [7:0]        INF_EXP        = 8'd255;
   localparam logic signed [9:0] MIN_NORMAL_EXP = -10'sd126;
   localparam logic signed [9:0] MAX_NORMAL_EXP = 10'sd127;

   // Unbiased exponents of the all-ones and all-zeros exponent fields.
   localparam logic signed [9:0] EXP_SPECIAL    = 10'sd128;
   localparam logic signed [9:0] EXP_ZERO       = -10'sd127;

   // Restoring division produces 27 quotient bits, one per cycle.
   localparam logic [4:0]        LAST_STEP      = 5'd26;

endpackage

// File: rtl/divider.sv
// Multi-cycle bfloat16 divider: operands are widened to float32, divided with
// a restoring shift-subtract loop, rounded to nearest-even, truncated back.
module divider
   import fp_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic [15:0]   input_a,
   input  logic [15:0]   input_b,
   input  logic          div_input_STB,
   output logic          div_BUSY,
   output logic [15:0]   output_div,
   output logic          div_output_STB,
   input  logic          output_module_BUSY,
   output logic [103:0]  state_name
);

   // Handshake: an operand pair is taken on a rising edge where div_input_STB=1
   // and div_BUSY=0 in get_a_and_b; a result is consumed on an edge where
   // div_output_STB=1 and output_module_BUSY=0, and output_div is held until then.

   state_t state, state_next;
   logic   busy_next, stb_next;
   logic   accept;

   logic [31:0]        a, b;
   logic [23:0]        a_m, b_m, z_m;
   logic signed [9:0]  a_e, b_e, z_e;
   logic               a_s, b_s, z_s;
   logic               guard, round_bit, sticky;

   logic [49:0]        dividend;
   logic [23:0]        divisor;
   logic [26:0]        quotient;
   logic [23:0]        remainder;
   logic [4:0]         count;

   logic [24:0]        trial;
   logic [23:0]        trial_diff;
   logic               step_ge;

   logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, special_hit;

   assign accept = (state == get_a_and_b) && !div_BUSY && div_input_STB;

   always_comb begin
      a_nan       = (a_e == EXP_SPECIAL) && (a_m != 24'd0);
      b_nan       = (b_e == EXP_SPECIAL) && (b_m != 24'd0);
      a_inf       = (a_e == EXP_SPECIAL) && (a_m == 24'd0);
      b_inf       = (b_e == EXP_SPECIAL) && (b_m == 24'd0);
      a_zero      = (a_e == EXP_ZERO) && (a_m == 24'd0);
      b_zero      = (b_e == EXP_ZERO) && (b_m == 24'd0);
      special_hit = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
   end

   // The top 23 dividend bits are a_m[23:1] < b_m, so their quotient bits are
   // known zero: the first step consumes all of a_m at once, later steps one bit.
   always_comb begin
      trial      = (count == 5'd0) ? {1'b0, dividend[49:26]} : {remainder, dividend[25]};
      step_ge    = trial >= {1'b0, divisor};
      trial_diff = 24'(trial - {1'b0, divisor});
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= get_a_and_b;
         div_BUSY       <= 1'b0;
         div_output_STB <= 1'b0;
      end else begin
         state          <= state_next;
         div_BUSY       <= busy_next;
         div_output_STB <= stb_next;
      end
   end

   always_comb begin
      state_next = state;
      busy_next  = div_BUSY;
      stb_next   = div_output_STB;
      case (state)
         get_a_and_b: begin
            if (accept) begin
               state_next = unpack;
               busy_next  = 1'b1;
            end else begin
               busy_next  = 1'b0;
            end
         end
         unpack:        state_next = special_cases;
         special_cases: state_next = special_hit ? put_z : normalise_a;
         normalise_a:   if (a_m[23]) state_next = normalise_b;
         normalise_b:   if (b_m[23]) state_next = divide_0;
         divide_0:      state_next = divide_1;
         divide_1:      if (count == LAST_STEP) state_next = divide_2;
         divide_2:      state_next = normalise_1;
         normalise_1:   if (z_m[23]) state_next = normalise_2;
         normalise_2:   if (!(z_e < MIN_NORMAL_EXP)) state_next = round;
         round:         state_next = pack;
         pack:          state_next = put_z;
         put_z: begin
            stb_next = 1'b1;
            if (div_output_STB && !output_module_BUSY) begin
               stb_next   = 1'b0;
               state_next = get_a_and_b;
            end
         end
         default:       state_next = get_a_and_b;
      endcase
   end

   always_ff @(posedge clk) begin
      case (state)
         get_a_and_b: begin
            if (accept) begin
               a <= {input_a, 16'h0000};
               b <= {input_b, 16'h0000};
            end
         end
         unpack: begin
            a_m <= {1'b0, a[22:0]};
            b_m <= {1'b0, b[22:0]};
            a_e <= $signed({2'b00, a[30:23]}) - BIAS;
            b_e <= $signed({2'b00, b[30:23]}) - BIAS;
            a_s <= a[31];
            b_s <= b[31];
         end
         special_cases: begin
            if (a_nan || b_nan) begin
               output_div <= NAN_BITS[31:16];
            end else if (a_inf && b_inf) begin
               output_div <= NAN_BITS[31:16];
            end else if (a_inf) begin
               output_div <= {a_s ^ b_s, INF_EXP, 7'd0};
            end else if (b_inf) begin
               output_div <= {a_s ^ b_s, 15'd0};
            end else if (b_zero && a_zero) begin
               output_div <= NAN_BITS[31:16];
            end else if (b_zero) begin
               output_div <= {a_s ^ b_s, INF_EXP, 7'd0};
            end else if (a_zero) begin
               output_div <= {a_s ^ b_s, 15'd0};
            end else begin
               if (a_e == EXP_ZERO) a_e <= MIN_NORMAL_EXP;
               else                 a_m[23] <= 1'b1;
               if (b_e == EXP_ZERO) b_e <= MIN_NORMAL_EXP;
               else                 b_m[23] <= 1'b1;
            end
         end
         normalise_a: begin
            if (!a_m[23]) begin
               a_m <= {a_m[22:0], 1'b0};
               a_e <= a_e - 10'sd1;
            end
         end
         normalise_b: begin
            if (!b_m[23]) begin
               b_m <= {b_m[22:0], 1'b0};
               b_e <= b_e - 10'sd1;
            end
         end
         divide_0: begin
            z_s       <= a_s ^ b_s;
            z_e       <= a_e - b_e;
            dividend  <= {a_m, 26'd0};
            divisor   <= b_m;
            quotient  <= 27'd0;
            remainder <= 24'd0;
            count     <= 5'd0;
         end
         divide_1: begin
            quotient  <= {quotient[25:0], step_ge};
            remainder <= step_ge ? trial_diff : trial[23:0];
            if (count != 5'd0) dividend <= {dividend[48:0], 1'b0};
            count     <= count + 5'd1;
         end
         divide_2: begin
            z_m       <= quotient[26:3];
            guard     <= quotient[2];
            round_bit <= quotient[1];
            sticky    <= quotient[0] | (remainder != 24'd0);
         end
         normalise_1: begin
            if (!z_m[23]) begin
               z_m       <= {z_m[22:0], guard};
               guard     <= round_bit;
               round_bit <= 1'b0;
               z_e       <= z_e - 10'sd1;
            end
         end
         normalise_2: begin
            if (z_e < MIN_NORMAL_EXP) begin
               z_m       <= {1'b0, z_m[23:1]};
               z_e       <= z_e + 10'sd1;
               guard     <= z_m[0];
               round_bit <= guard;
               sticky    <= sticky | round_bit;
            end
         end
         round: begin
            if (guard && (round_bit || sticky || z_m[0])) begin
               z_m <= z_m + 24'd1;
               if (z_m == 24'hFF_FFFF) z_e <= z_e + 10'sd1;
            end
         end
         pack: begin
            // Only the upper half of the float32 result leaves the block.
            if (z_e > MAX_NORMAL_EXP)
               output_div <= {z_s, INF_EXP, 7'd0};
            else if ((z_e == MIN_NORMAL_EXP) && !z_m[23])
               output_div <= {z_s, 8'd0, z_m[22:16]};
            else
               output_div <= {z_s, 8'(z_e + BIAS), z_m[22:16]};
         end
         default: ;
      endcase
   end

   always_comb begin
      state_name = "unknown";
      case (state)
         get_a_and_b:   state_name = "get_a_and_b";
         unpack:        state_name = "unpack";
         special_cases: state_name = "special_cases";
         normalise_a:   state_name = "normalise_a";
         normalise_b:   state_name = "normalise_b";
         divide_0:      state_name = "divide_0";
         divide_1:      state_name = "divide_1";
         divide_2:      state_name = "divide_2";
         normalise_1:   state_name = "normalise_1";
         normalise_2:   state_name = "normalise_2";
         round:         state_name = "round";
         pack:          state_name = "pack";
         put_z:         state_name = "put_z";
         default:       state_name = "unknown";
      endcase
   end

endmodule

// File: tb/tb_divider.sv
// Directed and randomised checks of the bfloat16 divider: results, latency,
// back-pressure, mid-operation reset and operand changes while busy.
module tb_divider;

   logic         clk = 1'b0;
   logic         rst;
   logic [15:0]  input_a, input_b;
   logic         div_input_STB;
   logic         div_BUSY;
   logic [15:0]  output_div;
   logic         div_output_STB;
   logic         output_module_BUSY;
   logic [103:0] state_name;

   int tests_run    = 0;
   int tests_failed = 0;
   logic [15:0] exp_q[$];

   divider dut (
      .clk                (clk),
      .rst                (rst),
      .input_a            (input_a),
      .input_b            (input_b),
      .div_input_STB      (div_input_STB),
      .div_BUSY           (div_BUSY),
      .output_div         (output_div),
      .div_output_STB     (div_output_STB),
      .output_module_BUSY (output_module_BUSY),
      .state_name         (state_name)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   // Normal bf16 operands only; long integer division with exact remainder.
   function automatic logic [15:0] model_div(input logic [15:0] a, input logic [15:0] b);
      logic [63:0] num, den, q, r, rest, half;
      logic [24:0] mant;
      int          e, sh;
      num  = {56'd0, 1'b1, a[6:0]} << 40;
      den  = {56'd0, 1'b1, b[6:0]};
      q    = num / den;
      r    = num % den;
      e    = int'(a[14:7]) - int'(b[14:7]);
      if (q[40]) sh = 17;
      else begin
         sh = 16;
         e  = e - 1;
      end
      mant = 25'(q >> sh);
      rest = q & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if ((rest > half) || ((rest == half) && ((r != 64'd0) || mant[0]))) mant = mant + 25'd1;
      if (mant[24]) begin
         mant = mant >> 1;
         e    = e + 1;
      end
      return {a[15] ^ b[15], 8'(e + 127), mant[22:16]};
   endfunction

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests_run++;
      assert (obs === expv) else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic send(input logic [15:0] a, input logic [15:0] b);
      int waited = 0;
      while (div_BUSY && waited < 100) begin
         @(posedge clk);
         #1;
         waited++;
      end
      check("send_ready", {31'd0, div_BUSY}, 32'd0);
      input_a       = a;
      input_b       = b;
      div_input_STB = 1'b1;
      @(posedge clk);
      #1;
      div_input_STB = 1'b0;
   endtask

   // Waits for a result, compares it with the scoreboard head, optionally holds
   // back-pressure for 'hold' cycles, then checks the STB / BUSY release order.
   task automatic collect(input string tag, input int lat, input int hold);
      int          n = 0;
      logic [15:0] expv;
      while (!div_output_STB && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({tag, "_latency"}, n, lat);
      expv = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hDEAD;
      check({tag, "_result"}, {16'd0, output_div}, {16'd0, expv});
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         check({tag, "_hold_stb"},  {31'd0, div_output_STB}, 32'd1);
         check({tag, "_hold_data"}, {16'd0, output_div}, {16'd0, expv});
         check({tag, "_hold_busy"}, {31'd0, div_BUSY}, 32'd1);
      end
      output_module_BUSY = 1'b0;
      @(posedge clk);
      #1;
      check({tag, "_stb_drop"},  {31'd0, div_output_STB}, 32'd0);
      check({tag, "_busy_held"}, {31'd0, div_BUSY}, 32'd1);
      @(posedge clk);
      #1;
      check({tag, "_busy_drop"}, {31'd0, div_BUSY}, 32'd0);
   endtask

   task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] expv, input int lat);
      exp_q.push_back(expv);
      send(a, b);
      collect(tag, lat, 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [15:0] ra, rb;
      int          rlat;

      rst                = 1'b1;
      input_a            = 16'h0000;
      input_b            = 16'h0000;
      div_input_STB      = 1'b0;
      output_module_BUSY = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", {31'd0, div_BUSY}, 32'd0);
      check("reset_stb",  {31'd0, div_output_STB}, 32'd0);
      rst = 1'b0;

      run_op("six_by_two",  16'h40C0, 16'h4000, 16'h4040, 38);
      run_op("one_third",   16'h3F80, 16'h4040, 16'h3EAA, 39);
      run_op("one_by_one",  16'h3F80, 16'h3F80, 16'h3F80, 38);
      run_op("div_by_zero", 16'h3F80, 16'h0000, 16'h7F80, 3);
      run_op("zero_zero",   16'h0000, 16'h0000, 16'hFFC0, 3);
      run_op("by_inf",      16'hBF80, 16'h7F80, 16'h8000, 3);
      run_op("nan_in",      16'h7FC1, 16'h3F80, 16'hFFC0, 3);
      run_op("denorm_a",    16'h0040, 16'h3E80, 16'h0100, 39);
      run_op("denorm_b",    16'h0080, 16'h0040, 16'h4000, 39);

      for (int i = 0; i < 6; i++) begin
         ra   = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 7'($urandom_range(0, 127))};
         rb   = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 7'($urandom_range(0, 127))};
         rlat = ({1'b1, ra[6:0]} >= {1'b1, rb[6:0]}) ? 38 : 39;
         run_op("random", ra, rb, model_div(ra, rb), rlat);
      end

      // Downstream stalls for 10 cycles while the result is presented.
      output_module_BUSY = 1'b1;
      exp_q.push_back(16'h4040);
      send(16'h4040, 16'h3F80);
      collect("backpressure", 38, 10);

      // Reset in the middle of the restoring loop abandons the operation.
      send(16'h4040, 16'h4000);
      repeat (10) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midreset_busy", {31'd0, div_BUSY}, 32'd0);
      check("midreset_stb",  {31'd0, div_output_STB}, 32'd0);
      rst = 1'b0;
      run_op("after_reset", 16'h4000, 16'h3F80, 16'h4000, 38);

      // New operands held valid while busy must not disturb the running result.
      exp_q.push_back(16'h3EAA);
      exp_q.push_back(16'h4000);
      send(16'h3F80, 16'h4040);
      input_a       = 16'h4000;
      input_b       = 16'h3F80;
      div_input_STB = 1'b1;
      collect("ignore_first", 39, 0);
      @(posedge clk);
      #1;
      div_input_STB = 1'b0;
      check("ignore_second_accept", {31'd0, div_BUSY}, 32'd1);
      collect("ignore_second", 38, 0);

      check("queue_empty", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
